// File: rtl/fifo_mem_pkg.sv
// fifo_mem_pkg: shared types and helpers for the banked FIFO storage array.
//   wstate_t    - write-side clear/run state
//   lane_parity - per-lane XOR reduction of a data word (lane count/width given by caller)
package fifo_mem_pkg;

    typedef enum logic {INIT, RUN} wstate_t;

    // Widest word lane_parity accepts; callers zero-extend into this width.
    localparam int MAX_W = 1024;

    function automatic logic [MAX_W-1:0] lane_parity(input logic [MAX_W-1:0] d,
                                                     input int lanes,
                                                     input int lane_w);
        logic [MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < lanes; i++)
            for (int j = 0; j < lane_w; j++)
                p[i] = p[i] ^ d[i*lane_w + j];
        return p;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop single-bit synchroniser with a synchronous active-low reset.
//   clk   - destination clock
//   rst_n - synchronous active-low reset, loads RST_VAL into both flops
//   d     - asynchronous input
//   q     - synchronised output
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_mem_banked.sv
// fifo_mem_banked: dual-clock FIFO storage with byte-lane writes, lane parity and hardware clear.
//   wclk, reset     - write clock and its synchronous active-low reset
//   rclk            - read clock
//   w_en, full      - write request, blocked while full
//   wbe/wadrs/wdata - per-lane write enable, write address, write data
//   r_en, empty     - read request, blocked while empty
//   radrs           - read address
//   rdata/rvalid    - read data and its one-cycle valid pulse (rclk)
//   par_err         - per-lane parity mismatch for the word presented with rvalid
//   init_busy       - post-reset clear in progress (wclk domain)
module fifo_mem_banked
    import fifo_mem_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int LANE_W  = 8,
    parameter  int DEPTH   = 32,
    parameter  int ADDR_W  = $clog2(DEPTH),
    parameter  int OUT_REG = 0,
    localparam int LANES   = WIDTH / LANE_W
) (
    input  logic              wclk,
    input  logic              reset,
    input  logic              rclk,
    input  logic              w_en,
    input  logic              full,
    input  logic [LANES-1:0]  wbe,
    input  logic [ADDR_W-1:0] wadrs,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              r_en,
    input  logic              empty,
    input  logic [ADDR_W-1:0] radrs,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic [LANES-1:0]  par_err,
    output logic              init_busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    wstate_t           state;
    logic [ADDR_W-1:0] init_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [LANES-1:0]  par [DEPTH];
    logic [LANES-1:0]  wpar;

    assign wpar = LANES'(lane_parity(MAX_W'(wdata), LANES, LANE_W));

    // Clear sequencer: one entry per wclk edge, leaving INIT on the edge that clears DEPTH-1.
    always_ff @(posedge wclk) begin
        if (!reset) begin
            state     <= INIT;
            init_ptr  <= '0;
            init_busy <= 1'b1;
        end else if (state == INIT) begin
            init_ptr <= init_ptr + 1'b1;
            if (init_ptr == LAST) begin
                state     <= RUN;
                init_busy <= 1'b0;
            end
        end
    end

    // Storage has no reset of its own; the clear sequencer zeroes it after every reset.
    always_ff @(posedge wclk) begin
        if (reset && state == INIT) begin
            mem[init_ptr] <= '0;
            par[init_ptr] <= '0;
        end else if (reset && state == RUN && w_en && !full) begin
            for (int i = 0; i < LANES; i++)
                if (wbe[i]) begin
                    mem[wadrs][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                    par[wadrs][i]                  <= wpar[i];
                end
        end
    end

    logic rrst_n, rbusy, rd_acc;

    sync_2ff #(.RST_VAL(1'b0)) u_rst_sync (
        .clk   (rclk),
        .rst_n (1'b1),
        .d     (reset),
        .q     (rrst_n)
    );

    sync_2ff #(.RST_VAL(1'b1)) u_busy_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (init_busy),
        .q     (rbusy)
    );

    assign rd_acc = r_en & ~empty & ~rbusy & rrst_n;

    logic [WIDTH-1:0] s1_data;
    logic [LANES-1:0] s1_perr;
    logic             s1_v;

    // Read-first: the array is sampled with its pre-edge contents.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_perr <= '0;
        end else begin
            s1_v <= rd_acc;
            if (rd_acc) begin
                s1_data <= mem[radrs];
                s1_perr <= par[radrs] ^ LANES'(lane_parity(MAX_W'(mem[radrs]), LANES, LANE_W));
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] s2_data;
        logic [LANES-1:0] s2_perr;
        logic             s2_v;
        always_ff @(posedge rclk) begin
            if (!rrst_n) begin
                s2_v    <= 1'b0;
                s2_data <= '0;
                s2_perr <= '0;
            end else begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_data <= s1_data;
                    s2_perr <= s1_perr;
                end
            end
        end
        assign rdata   = s2_data;
        assign rvalid  = s2_v;
        assign par_err = s2_perr;
    end else begin : g_noreg
        assign rdata   = s1_data;
        assign rvalid  = s1_v;
        assign par_err = s1_perr;
    end

endmodule

// File: tb/tb_fifo_mem_banked.sv
// tb_fifo_mem_banked: randomised and directed scoreboard bench for fifo_mem_banked.
module tb_fifo_mem_banked;

    localparam int WIDTH   = 32;
    localparam int LANE_W  = 8;
    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int OUT_REG = 1;
    localparam int LANES   = 4;

    logic             wclk, rclk, reset;
    logic             w_en, full, r_en, empty;
    logic [LANES-1:0] wbe;
    logic [AW-1:0]    wadrs, radrs;
    logic [WIDTH-1:0] wdata, rdata;
    logic             rvalid, init_busy;
    logic [LANES-1:0] par_err;

    fifo_mem_banked #(
        .WIDTH   (WIDTH),
        .LANE_W  (LANE_W),
        .DEPTH   (DEPTH),
        .OUT_REG (OUT_REG)
    ) dut (
        .wclk      (wclk),
        .reset     (reset),
        .rclk      (rclk),
        .w_en      (w_en),
        .full      (full),
        .wbe       (wbe),
        .wadrs     (wadrs),
        .wdata     (wdata),
        .r_en      (r_en),
        .empty     (empty),
        .radrs     (radrs),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .par_err   (par_err),
        .init_busy (init_busy)
    );

    // DUT edges land on odd times, bench drives and samples on even times.
    initial begin
        wclk = 0;
        forever #5 wclk = ~wclk;
    end

    initial begin
        rclk = 0;
        #3;
        forever begin
            rclk = 1;
            #7;
            rclk = 0;
            #7;
        end
    end

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [LANES-1:0] pe;
        int               cyc;
    } exp_t;

    exp_t             sbq[$];
    logic [WIDTH-1:0] mdl  [DEPTH];
    logic [LANES-1:0] merr [DEPTH];
    int               checks = 0;
    int               fails  = 0;
    int               rcyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge rclk) rcyc++;

    always @(negedge rclk) begin
        if (rvalid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rvalid: got rdata %h with no read outstanding", rdata);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rd_data", 64'(rdata), 64'(e.d));
                chk("rd_perr", 64'(par_err), 64'(e.pe));
                chk("rd_latency", 64'(rcyc), 64'(e.cyc));
            end
        end
    end

    task automatic mdl_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i]  = '0;
            merr[i] = '0;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                      input logic [LANES-1:0] be, input logic f);
        @(negedge wclk);
        w_en = 1; wadrs = a; wdata = d; wbe = be; full = f;
        @(negedge wclk);
        w_en = 0; full = 0;
        if (!f)
            for (int i = 0; i < LANES; i++)
                if (be[i]) begin
                    mdl[a][i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
                    merr[a][i] = 1'b0;
                end
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic en, input logic emp);
        exp_t e;
        @(negedge rclk);
        r_en = en; radrs = a; empty = emp;
        if (en && !emp) begin
            e.d   = mdl[a];
            e.pe  = merr[a];
            e.cyc = rcyc + 1 + OUT_REG;
            sbq.push_back(e);
        end
    endtask

    task automatic rd_idle();
        @(negedge rclk);
        r_en = 0; empty = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge rclk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d reads outstanding expected 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge rclk);
    endtask

    task automatic release_and_count();
        int cnt;
        @(negedge wclk);
        reset = 1;
        cnt = 0;
        while (init_busy && cnt < 100) begin
            @(negedge wclk);
            cnt++;
        end
        chk("init_busy_cycles", 64'(cnt), 64'(DEPTH));
        repeat (4) @(negedge rclk);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), 1'b1, 1'b0);
        rd_idle();
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; w_en = 0; full = 0; wbe = '0; wadrs = '0; wdata = '0;
        r_en = 0; empty = 0; radrs = '0;
        mdl_clear();
        repeat (6) @(negedge rclk);
        chk("rst_init_busy", 64'(init_busy), 64'(1));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_par_err", 64'(par_err), 64'(0));

        release_and_count();
        read_all();

        wr(5, 32'hDEADBEEF, 4'b1111, 1'b0);
        wr(5, 32'h000000AA, 4'b0001, 1'b0);
        repeat (3) @(negedge rclk);
        rd(5, 1'b1, 1'b0);
        rd_idle();
        drain();
        chk("lane_merge", 64'(rdata), 64'(32'hDEADBEAA));

        repeat (4) rd(3, 1'b1, 1'b1);
        rd_idle();
        repeat (4) @(negedge rclk);
        chk("empty_holds_rdata", 64'(rdata), 64'(32'hDEADBEAA));

        wr(3, 32'hFFFFFFFF, 4'b1111, 1'b1);
        repeat (3) @(negedge rclk);
        rd(3, 1'b1, 1'b0);
        rd_idle();
        drain();
        chk("full_blocks", 64'(rdata), 64'(0));

        for (int i = 0; i < 4; i++) wr(AW'(i), 32'h1111_0000 + 32'(i * 16'h0101), 4'b1111, 1'b0);
        repeat (3) @(negedge rclk);
        for (int i = 0; i < 4; i++) rd(AW'(i), 1'b1, 1'b0);
        rd_idle();
        drain();
        chk("burst_last", 64'(rdata), 64'(32'h1111_0303));

        wr(7, 32'h0F0F_3C3C, 4'b1111, 1'b0);
        repeat (3) @(negedge rclk);
        dut.mem[7] = dut.mem[7] ^ 32'h0000_0200;
        mdl[7]  = mdl[7] ^ 32'h0000_0200;
        merr[7] = merr[7] ^ 4'b0010;
        rd(7, 1'b1, 1'b0);
        rd_idle();
        drain();
        chk("parity_flip", 64'(par_err), 64'(4'b0010));

        repeat (150)
            wr(AW'($urandom_range(0, DEPTH - 1)), $urandom, LANES'($urandom),
               $urandom_range(0, 3) == 0);
        repeat (3) @(negedge rclk);
        repeat (80)
            rd(AW'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 4) == 0);
        rd_idle();
        drain();

        wr(9, 32'hCAFE_F00D, 4'b1111, 1'b0);
        repeat (3) @(negedge rclk);
        @(negedge rclk);
        reset = 0;
        @(negedge rclk);
        r_en = 1; radrs = 9; empty = 0;
        @(negedge rclk);
        r_en = 0;
        repeat (6) @(negedge rclk);
        chk("abort_rvalid", 64'(rvalid), 64'(0));
        chk("abort_rdata", 64'(rdata), 64'(0));
        chk("abort_busy", 64'(init_busy), 64'(1));

        @(negedge wclk);
        reset = 1;
        repeat (10) @(negedge wclk);
        reset = 0;
        repeat (3) @(negedge wclk);
        mdl_clear();
        release_and_count();
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fifo_mem_banked.md
# fifo_mem_banked

Dual-clock storage array for the async FIFO, generalising the existing FIFO memory with parametrised width and depth, byte-lane write enables, per-lane parity, and an optional output register. After every reset it runs a hardware clear, then serves writes on `wclk` and reads on `rclk`. It sits between the FIFO write-pointer/full logic and the read-pointer/empty logic.

## Interface
- `WIDTH`, default 32: data word width. Must be a multiple of `LANE_W`.
- `LANE_W`, default 8: byte-lane width. `LANES = WIDTH/LANE_W`.
- `DEPTH`, default 32: number of entries. Must be a power of 2, at least 2.
- `ADDR_W`, default `$clog2(DEPTH)`: address width.
- `OUT_REG`, default 0: 0 gives 1-cycle read latency; 1 gives 2-cycle read latency.
- `wclk` input, 1: write-domain clock.
- `reset` input, 1: reset, synchronous, active-low; clock wclk.
- `rclk` input, 1: read-domain clock.
- `w_en` input, 1: write request.
- `full` input, 1: FIFO full. Blocks writes.
- `wbe` input, `LANES`: per-lane write enable.
- `wadrs` input, `ADDR_W`: write address.
- `wdata` input, `WIDTH`: write data.
- `r_en` input, 1: read request.
- `empty` input, 1: FIFO empty. Blocks reads.
- `radrs` input, `ADDR_W`: read address.
- `rdata` output, `WIDTH`: read data.
- `rvalid` output, 1: 1-cycle pulse (`rclk`) marking new `rdata`.
- `par_err` output, `LANES`: per-lane parity mismatch, qualified by `rvalid`.
- `init_busy` output, 1: clear in progress (`wclk` domain).

## Operation
- Storage is a `DEPTH` x `WIDTH` data array plus a `DEPTH` x `LANES` parity array. The parity bit for a lane is the XOR of that lane's data bits.
- Write-side FSM on `wclk` has two states, INIT and RUN:
  - While `reset` = 0: state = INIT, `init_ptr` = 0, `init_busy` = 1.
  - INIT with `reset` = 1: write 0 to data and parity at `init_ptr`, then increment `init_ptr`. After the write to `DEPTH-1`, move to RUN and drop `init_busy` on that same edge.
  - The clear therefore takes exactly `DEPTH` `wclk` cycles after reset release.
  - RUN: holds until `reset` goes low.
- A write is accepted in RUN when `w_en` & ~`full`. For each lane i with `wbe[i]` = 1, data lane i and parity bit i at `wadrs` are updated. Lanes with `wbe[i]` = 0 are left unchanged. `wbe` = 0 is a no-op.
- Writes during INIT, or while `full` = 1, are dropped silently.
- Read domain:
  - `reset` passes through a 2-flop synchroniser to `rclk`, producing `rrst_n`.
  - `init_busy` passes through a 2-flop synchroniser to `rclk`, producing `rbusy`; its reset value is 1.
  - A read is accepted when `r_en` & ~`empty` & ~`rbusy` & `rrst_n`.
- An accepted read captures `mem[radrs]` and computes `par_err[i]` = stored parity XOR recomputed lane parity. With `OUT_REG` = 1, one further register stage follows.
- `rdata` holds its last value when no read completes.
- Same-address write and read in the same instant (common clock) returns the old data (read-first). With truly asynchronous clocks, the FIFO pointer logic guarantees no collision.

## Timing
- Reset values:
  - `init_busy` = 1.
  - `rdata` = 0, `rvalid` = 0, `par_err` = 0, applied while `rrst_n` = 0.
  - The read pipeline is flushed within 3 `rclk` cycles of `reset` falling.
- Read latency: `rvalid` rises 1 (`OUT_REG` = 0) or 2 (`OUT_REG` = 1) `rclk` edges after the accepting edge.
- Back-to-back reads give one result per cycle.
- Write latency: data is readable from the `wclk` edge after acceptance.
- Reset mid-clear: INIT restarts from `init_ptr` = 0.
- Reset mid-RUN: array contents are re-cleared, and in-flight reads are discarded (no `rvalid`).
- `init_ptr` is `ADDR_W` bits wide. There is no wrap: the FSM leaves INIT on `init_ptr` = `DEPTH-1`.

## Structure
- Package `fifo_mem_pkg` holds:
  - the `wstate_t` enum {INIT, RUN};
  - the `lane_parity` function (WIDTH/LANE_W generic XOR reduction).
- Sub-module `sync_2ff` (1-bit, reset value parameter) is instantiated twice: once for `reset` and once for `init_busy`.
- The array is inferred. No vendor macros.

## Test plan
- Release reset with `DEPTH` = 32: `init_busy` = 1 for exactly 32 `wclk` cycles. Reads of every address then return 0 with `par_err` = 0.
- Write 0xDEADBEEF to address 5 with `wbe` = 4'b1111, then write 0x000000AA with `wbe` = 4'b0001 → read of address 5 returns 0xDEADBEAA.
- Assert `w_en` with `full` = 1 on address 3 → address 3 still reads 0. Assert `r_en` with `empty` = 1 → no `rvalid`.
- `OUT_REG` = 1, 4 back-to-back reads of addresses 0..3 → 4 consecutive `rvalid` pulses starting 2 `rclk` edges after the first accept, with data in order.
- Backdoor-flip bit 9 of entry 7, then read address 7 → `par_err` = 4'b0010 with `rvalid`.
- Drop `reset` during the INIT clear at `init_ptr` = 10 and mid-read → clear restarts at 0, no `rvalid` for the aborted read, `rdata` = 0.
